// File: rtl/fpmult_pkg.sv
// Shared types and constants for the sequential single-precision multiplier.
package fpmult_pkg;

    localparam int BIAS = 127;
    localparam int EXPW = 10;
    localparam int PW   = 48;
    localparam int MW   = 24;

    localparam logic [7:0]  EXP_INF   = 8'hFF;
    localparam logic [22:0] QNAN_MANT = 23'h400000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_e;

    // Unbiased-then-rebiased product exponent, wide enough to hold -127..383.
    function automatic logic signed [EXPW-1:0] biased_sum(
        input logic [7:0] ea,
        input logic [7:0] eb,
        input int         bias
    );
        logic [EXPW-1:0] s;
        s = {2'b00, ea} + {2'b00, eb} - EXPW'(bias);
        return s;
    endfunction

endpackage

// File: rtl/fpmult_if.sv
// Start/done request bus between a requester and the multiplier core.
interface fpmult_if;

    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        signin;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        ovf;
    logic        unf;

    modport master (
        output start, a, b, signin,
        input  busy, done, result, ovf, unf
    );

    modport slave (
        input  start, a, b, signin,
        output busy, done, result, ovf, unf
    );

endinterface

// File: rtl/fpmult_normpack.sv
// Combinational normalize/pack stage with the special-case priority chain.
module fpmult_normpack #(
    parameter int BIAS = 127
) (
    input  logic [fpmult_pkg::PW-1:0] p_i,
    input  logic [7:0]                ea_i,
    input  logic [7:0]                eb_i,
    input  logic                      sign_i,
    output logic [31:0]               result_o,
    output logic                      ovf_o,
    output logic                      unf_o
);
    import fpmult_pkg::*;

    localparam logic signed [EXPW-1:0] E_MAX = EXPW'(255);

    logic signed [EXPW-1:0] e_base;
    logic signed [EXPW-1:0] e_norm;
    logic [22:0]            mant;
    logic                   a_inf, b_inf, a_zero, b_zero;

    assign e_base = biased_sum(ea_i, eb_i, BIAS);
    assign e_norm = p_i[PW-1] ? e_base + EXPW'(1) : e_base;
    assign mant   = p_i[PW-1] ? p_i[PW-2 -: 23] : p_i[PW-3 -: 23];

    assign a_inf  = (ea_i == EXP_INF);
    assign b_inf  = (eb_i == EXP_INF);
    assign a_zero = (ea_i == 8'h00);
    assign b_zero = (eb_i == 8'h00);

    always_comb begin
        result_o = {sign_i, 31'b0};
        ovf_o    = 1'b0;
        unf_o    = 1'b0;
        if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            result_o = {sign_i, EXP_INF, QNAN_MANT};
        end else if (a_inf || b_inf) begin
            // NaN operands collapse to infinity; payloads are dropped.
            result_o = {sign_i, EXP_INF, 23'b0};
        end else if (a_zero || b_zero) begin
            result_o = {sign_i, 31'b0};
        end else if (e_norm >= E_MAX) begin
            result_o = {sign_i, EXP_INF, 23'b0};
            ovf_o    = 1'b1;
        end else if (e_norm <= 0) begin
            result_o = {sign_i, 31'b0};
            unf_o    = 1'b1;
        end else begin
            result_o = {sign_i, e_norm[7:0], mant};
        end
    end

endmodule

// File: rtl/fpmult_core.sv
// Sequential IEEE-754 single-precision multiplier: one shift-add step per
// clock over the 24-bit mantissas, then a single normalize/pack cycle.
module fpmult_core #(
    parameter int BIAS = 127,
    parameter int MW   = 24
) (
    input  logic     clk,
    input  logic     rst_n,
    fpmult_if.slave  bus
);
    import fpmult_pkg::*;

    localparam int CW = $clog2(MW);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    p_q, p_d;
    logic [MW-1:0]    ma_q, ma_d;
    logic [MW-1:0]    mb_q, mb_d;
    logic [7:0]       ea_q, ea_d;
    logic [7:0]       eb_q, eb_d;
    logic             sign_q, sign_d;
    logic [31:0]      result_q, result_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             done_q, done_d;

    logic [PW-1:0]    ma_ext;
    logic [31:0]      np_result;
    logic             np_ovf;
    logic             np_unf;

    assign ma_ext = {{(PW-MW){1'b0}}, ma_q};

    fpmult_normpack #(.BIAS(BIAS)) u_normpack (
        .p_i      (p_q),
        .ea_i     (ea_q),
        .eb_i     (eb_q),
        .sign_i   (sign_q),
        .result_o (np_result),
        .ovf_o    (np_ovf),
        .unf_o    (np_unf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            p_q      <= '0;
            ma_q     <= '0;
            mb_q     <= '0;
            ea_q     <= '0;
            eb_q     <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            ea_q     <= ea_d;
            eb_q     <= eb_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        ea_d     = ea_q;
        eb_d     = eb_q;
        sign_d   = sign_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        done_d   = done_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = MULT;
                    sign_d  = bus.signin;
                    ea_d    = bus.a[30:23];
                    eb_d    = bus.b[30:23];
                    ma_d    = {1'b1, bus.a[22:0]};
                    mb_d    = {1'b1, bus.b[22:0]};
                    p_d     = '0;
                    cnt_d   = '0;
                end
            end
            MULT: begin
                if (mb_q[cnt_q]) begin
                    p_d = p_q + (ma_ext << cnt_q);
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(MW-1)) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                result_d = np_result;
                ovf_d    = np_ovf;
                unf_d    = np_unf;
                done_d   = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                done_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.ovf    = ovf_q;
    assign bus.unf    = unf_q;

endmodule

// File: tb/tb_fpmult_core.sv
// Scoreboard bench for fpmult_core: directed products with hand-computed results.
module tb_fpmult_core;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpmult_if bus ();

    fpmult_core #(.BIAS(127), .MW(24)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        int unsigned cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;
    logic        done_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (bus.done === 1'b1) begin
            check("done_single_cycle", {31'b0, done_prev}, 32'd0);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done got result %h expected no done", bus.result);
            end else begin
                e = sb_q.pop_front();
                check("result", bus.result, e.res);
                check("ovf", {31'b0, bus.ovf}, {31'b0, e.ovf});
                check("unf", {31'b0, bus.unf}, {31'b0, e.unf});
                check("latency", cyc - e.cyc, 32'd25);
                $display("txn result=%h ovf=%0b unf=%0b latency=%0d", bus.result, bus.ovf, bus.unf, cyc - e.cyc);
            end
        end
        done_prev = bus.done;
    end

    // Called at a negedge with the core idle; returns at the next negedge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] er, input logic eo, input logic eu, input bit expect_done);
        exp_t e;
        bus.a      = a;
        bus.b      = b;
        bus.signin = s;
        bus.start  = 1'b1;
        if (expect_done) begin
            e.res = er; e.ovf = eo; e.unf = eu; e.cyc = cyc + 1;
            sb_q.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_accept", {31'b0, bus.busy}, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy === 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("idle_within_budget", {31'b0, bus.busy}, 32'd0);
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                       input logic eo, input logic eu);
        issue(a, b, a[31] ^ b[31], er, eo, eu, 1'b1);
        wait_idle();
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        bus.signin = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy",   {31'b0, bus.busy}, 32'd0);
        check("reset_done",   {31'b0, bus.done}, 32'd0);
        check("reset_result", bus.result, 32'd0);
        check("reset_ovf",    {31'b0, bus.ovf}, 32'd0);
        check("reset_unf",    {31'b0, bus.unf}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run(32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0);  // 2.0 * 3.0
        run(32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b0);  // 1.5 * 1.5, P[47]=1
        run(32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0, 1'b0);  // -2.0 * 3.0
        run(32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0);  // overflow
        run(32'h00000000, 32'h40400000, 32'h00000000, 1'b0, 1'b0);  // zero operand
        run(32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1);  // underflow
        run(32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0);  // inf * 0 -> qNaN
        run(32'h7F800000, 32'h40000000, 32'h7F800000, 1'b0, 1'b0);  // inf * 2.0
        run(32'h7FC00001, 32'hC0000000, 32'hFF800000, 1'b0, 1'b0);  // NaN treated as inf
        run(32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1, 1'b0);  // e == 255
        run(32'h7F000000, 32'h3F800000, 32'h7F000000, 1'b0, 1'b0);  // e == 254
        run(32'h7F400000, 32'h3FC00000, 32'h7F800000, 1'b1, 1'b0);  // 254 bumped to 255
        run(32'h00800000, 32'h3F000000, 32'h00000000, 1'b0, 1'b1);  // e == 0
        run(32'h00800000, 32'h3F800000, 32'h00800000, 1'b0, 1'b0);  // e == 1

        // Starts at T+5 and T+26 must be ignored.
        issue(32'h40000000, 32'h40400000, 1'b0, 32'h40C00000, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        bus.a = 32'h3F800000; bus.b = 32'h3F800000; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        check("done_at_T25", {31'b0, bus.done}, 32'd1);
        bus.a = 32'h40800000; bus.b = 32'h40800000; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("idle_after_T26", {31'b0, bus.busy}, 32'd0);
        @(negedge clk);
        check("no_queued_start", {31'b0, bus.busy}, 32'd0);
        check("result_held", bus.result, 32'h40C00000);

        // Reset mid-operation at T+10.
        issue(32'h40000000, 32'h40400000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy",   {31'b0, bus.busy}, 32'd0);
        check("abort_result", bus.result, 32'd0);
        check("abort_done",   {31'b0, bus.done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("abort_stays_idle", {31'b0, bus.busy}, 32'd0);
        run(32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpmult_core.md
# fpmult_core

Sequential IEEE-754 single-precision multiplier core for the FPU path of the 32-bit RISC datapath. It sits directly downstream of the `multsign` sign stage and consumes that stage's XOR sign bit. It computes the exponent sum and a 24x24 shift-add mantissa product, then normalizes and packs the 32-bit result. A start/done handshake is used, and the core can only be restarted once it has returned to IDLE.

## Interface
Parameters:
- `BIAS`, 127: exponent bias.
- `MW`, 24: mantissa width, hidden bit included; sets the iteration count.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  32  operand A, IEEE-754 single precision.
- `b`  in  32  operand B, IEEE-754 single precision.
- `signin`  in  1  product sign from `multsign`; equals `a[31]^b[31]`; sampled with `start`.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse; `result`, `ovf` and `unf` are valid while it is high.
- `result`  out  32  packed product; held until the next accepted `start`.
- `ovf`  out  1  exponent overflow; result saturated to infinity.
- `unf`  out  1  exponent underflow; result flushed to zero.

## Operation
- States: IDLE, MULT, NORM, DONE.
  - IDLE: `start`=1 → MULT. On that edge, capture `signin`, `ea`=`a[30:23]`, `eb`=`b[30:23]`, `ma`={1,`a[22:0]`}, `mb`={1,`b[22:0]`}, clear the 48-bit accumulator `P`, set `cnt`=0.
  - MULT: each edge, if `mb[cnt]` then `P += ma << cnt`; increment `cnt`. When `cnt`=23 is processed → NORM.
  - NORM: normalize and pack; register `result`, `ovf`, `unf`; `done`←1 → DONE.
  - DONE: `done`←0 → IDLE.
- Width rules:
  - Exponent arithmetic uses 10-bit signed values: `e = ea + eb - BIAS`.
  - If `P[47]`=1: mantissa = `P[46:24]`, `e = e+1`.
  - Otherwise: mantissa = `P[45:23]`.
  - Truncation only; no rounding.
- Special cases, evaluated in NORM in priority order:
  1. Either exponent is 255 and the other operand has exponent 0 → qNaN {`s`,8'hFF,23'h400000}.
  2. Either exponent is 255 → infinity {`s`,8'hFF,0}; `ovf`=0.
  3. Either exponent is 0 (zero or denormal, flushed) → {`s`,31'b0}; `unf`=0.
  4. `e` ≥ 255 → infinity; `ovf`=1.
  5. `e` ≤ 0 → {`s`,31'b0}; `unf`=1.
  6. Otherwise → {`s`, `e[7:0]`, mantissa}.
- NaN operands are handled as infinity (rule 2); NaN payloads are not propagated.
- `start` in MULT, NORM or DONE is ignored: no queuing, no error flag.
- `a`, `b` and `signin` may change freely after the accepting edge.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `ovf`=0, `unf`=0, state=IDLE, `cnt`=0, `P`=0.
- Reset asserted mid-operation aborts the operation immediately. No `done` is produced, and outputs take their reset values.
- Let start be accepted at edge T:
  - `busy` is high from T until edge T+26.
  - MULT runs on edges T+1 through T+24.
  - NORM runs on edge T+25.
  - `done` is high during the cycle following edge T+25; latency is 25 clocks.
- The earliest next accepted `start` is at edge T+27, when the core is back in IDLE.
- Throughput is one product per 27 cycles.
- `done` is never high for more than one cycle.

## Structure
- Shared package `fpmult_pkg` holds:
  - the state enum (IDLE/MULT/NORM/DONE),
  - `BIAS`,
  - constants `EXP_INF`=8'hFF and `QNAN_MANT`=23'h400000,
  - widths `EXPW`=10 and `PW`=48.
- One combinational sub-module, `fpmult_normpack`. Inputs: `P`, `ea`, `eb`, sign. Outputs: `result`, `ovf`, `unf`. It implements normalization and the special-case priority.
- The FSM, counter and shift-add accumulator live in `fpmult_core`.

## Test plan
- `a`=0x40000000 (2.0), `b`=0x40400000 (3.0), `signin`=0 → `result`=0x40C00000 with `done` exactly 25 clocks after start; `ovf`=`unf`=0.
- `a`=0x3FC00000, `b`=0x3FC00000 (1.5×1.5) → 0x40100000; exercises the `P[47]`=1 normalization path.
- `a`=0xC0000000, `b`=0x40400000, `signin`=1 → 0xC0C00000. Then 0x7F000000 × 0x7F000000 → 0x7F800000 with `ovf`=1.
- `a`=0x00000000, `b`=0x40400000 → 0x00000000. Then 0x00800000 × 0x00800000 → 0x00000000 with `unf`=1. Then 0x7F800000 × 0x00000000 → 0x7FC00000.
- Start 2.0×3.0, then pulse `start` with new operands at T+5 and T+26 → both ignored; a single `done` is produced with 0x40C00000.
- Start, then assert `rst_n`=0 at T+10 for 2 cycles → `busy`=0 immediately and `result`=0. No `done` appears. A fresh start after release completes normally.
